// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the fetch / load-store memory arbiter.
package mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 11;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned LOCK_CNT_W = 8;

   // Bus ownership: owner of the most recent grant, IDLE when nothing was granted.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_OWN  = 2'd1,
      LS_OWN  = 2'd2,
      LS_LOCK = 2'd3
   } arb_state_e;

endpackage : mem_arb_pkg

// File: rtl/arb_rr2.sv
// Two-way round-robin pick between fetch and load/store with a lock override.
module arb_rr2 (
   input  logic if_req_i,
   input  logic ls_req_i,
   input  logic prio_ls_i,
   input  logic lock_i,
   input  logic lock_expired_i,
   output logic if_pick_o,
   output logic ls_pick_o
);

   // Lock keeps the bus with load/store until it expires against a waiting fetch.
   always_comb begin
      if_pick_o = 1'b0;
      ls_pick_o = 1'b0;
      if (lock_i) begin
         if (ls_req_i && !(lock_expired_i && if_req_i)) begin
            ls_pick_o = 1'b1;
         end else if (if_req_i) begin
            if_pick_o = 1'b1;
         end
      end else if (if_req_i && ls_req_i) begin
         ls_pick_o = prio_ls_i;
         if_pick_o = ~prio_ls_i;
      end else begin
         if_pick_o = if_req_i;
         ls_pick_o = ls_req_i;
      end
   end

endmodule : arb_rr2

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port synchronous memory between a fetch port and a load/store port.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned LOCK_MAX = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic              ls_lock,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [DATA_W-1:0] ls_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_w_en,
   input  logic [DATA_W-1:0] mem_data_out
);

   arb_state_e            state_q;
   logic [LOCK_CNT_W-1:0] lock_cnt_q;
   logic                  prio_ls_q;
   logic                  if_rvalid_q;
   logic                  ls_rvalid_q;
   logic [ADDR_W-1:0]     mem_addr_q;
   logic [DATA_W-1:0]     mem_data_q;

   logic if_pick;
   logic ls_pick;
   logic lock_active;
   logic lock_expired;
   logic [LOCK_CNT_W-1:0] lock_cnt_inc;

   assign lock_active  = (state_q == LS_LOCK);
   assign lock_expired = (lock_cnt_q >= LOCK_CNT_W'(LOCK_MAX));
   assign lock_cnt_inc = (lock_cnt_q == '1) ? lock_cnt_q : lock_cnt_q + LOCK_CNT_W'(1);

   arb_rr2 u_arb_rr2 (
      .if_req_i       (if_req),
      .ls_req_i       (ls_req),
      .prio_ls_i      (prio_ls_q),
      .lock_i         (lock_active),
      .lock_expired_i (lock_expired),
      .if_pick_o      (if_pick),
      .ls_pick_o      (ls_pick)
   );

   // Grants are combinational so a lone requester gets the bus with zero wait; reset kills them at once.
   assign if_gnt   = rst_n & if_pick;
   assign ls_gnt   = rst_n & ls_pick;
   assign mem_w_en = ls_gnt & ls_we;

   // Granted requester drives the memory; otherwise address and write data hold their last value.
   always_comb begin
      mem_addr    = mem_addr_q;
      mem_data_in = mem_data_q;
      if (if_gnt) begin
         mem_addr = if_addr;
      end else if (ls_gnt) begin
         mem_addr    = ls_addr;
         mem_data_in = ls_wdata;
      end
   end

   // Memory data is only forwarded to the owner of the read, and only in its valid cycle.
   assign if_rvalid = if_rvalid_q;
   assign ls_rvalid = ls_rvalid_q;
   assign if_rdata  = if_rvalid_q ? mem_data_out : '0;
   assign ls_rdata  = ls_rvalid_q ? mem_data_out : '0;

   // Hold registers for the memory address/data bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr_q <= '0;
         mem_data_q <= '0;
      end else begin
         mem_addr_q <= mem_addr;
         mem_data_q <= mem_data_in;
      end
   end

   // Ownership FSM, lock counter, round-robin pointer and read-valid pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         lock_cnt_q  <= '0;
         prio_ls_q   <= 1'b0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
      end else begin
         if_rvalid_q <= if_gnt;
         ls_rvalid_q <= ls_gnt & ~ls_we;
         if (if_gnt) begin
            state_q    <= IF_OWN;
            prio_ls_q  <= 1'b1;
            lock_cnt_q <= '0;
         end else if (ls_gnt) begin
            prio_ls_q <= 1'b0;
            if (ls_lock) begin
               state_q    <= LS_LOCK;
               lock_cnt_q <= lock_active ? lock_cnt_inc : LOCK_CNT_W'(1);
            end else begin
               state_q    <= LS_OWN;
               lock_cnt_q <= '0;
            end
         end else begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
         end
      end
   end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant checks per vector, read data via a scoreboard queue.
module tb_mem_arbiter;

   localparam int unsigned AW = 11;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          ls_req;
   logic          ls_we;
   logic          ls_lock;
   logic [AW-1:0] ls_addr;
   logic [DW-1:0] ls_wdata;
   logic          ls_gnt;
   logic          ls_rvalid;
   logic [DW-1:0] ls_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data_in;
   logic          mem_w_en;
   logic [DW-1:0] mem_data_out;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      bit          port;   // 0 = fetch, 1 = load/store
      logic [31:0] data;
   } exp_rd_t;

   exp_rd_t sb[$];
   logic [AW-1:0] last_addr;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_gnt       (if_gnt),
      .if_rvalid    (if_rvalid),
      .if_rdata     (if_rdata),
      .ls_req       (ls_req),
      .ls_we        (ls_we),
      .ls_lock      (ls_lock),
      .ls_addr      (ls_addr),
      .ls_wdata     (ls_wdata),
      .ls_gnt       (ls_gnt),
      .ls_rvalid    (ls_rvalid),
      .ls_rdata     (ls_rdata),
      .mem_addr     (mem_addr),
      .mem_data_in  (mem_data_in),
      .mem_w_en     (mem_w_en),
      .mem_data_out (mem_data_out)
   );

   // Synchronous memory: preloaded with 0xA5000000 | index, read data one cycle after the address.
   logic [DW-1:0] mem [2**AW];
   logic mem_ready = 1'b0;
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 2**AW; i++) mem[i] <= 32'hA500_0000 | 32'(i);
         mem_ready <= 1'b1;
      end else if (mem_w_en) begin
         mem[mem_addr] <= mem_data_in;
      end
      mem_data_out <= mem[mem_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // One cycle of stimulus: apply at negedge, check grants/memory bus, queue the expected read.
   task automatic vec(input logic ir, input logic [AW-1:0] ia, input logic lr, input logic we,
                      input logic lk, input logic [AW-1:0] la, input logic [31:0] wd,
                      input logic e_if, input logic e_ls, input logic [31:0] e_rd, input bit push);
      exp_rd_t e;
      @(negedge clk);
      if_req = ir; if_addr = ia; ls_req = lr; ls_we = we; ls_lock = lk; ls_addr = la; ls_wdata = wd;
      #1;
      chk("gnt", 32'({if_gnt, ls_gnt}), 32'({e_if, e_ls}));
      chk("mem_w_en", 32'(mem_w_en), 32'(e_ls & we));
      if (e_if) last_addr = ia;
      else if (e_ls) last_addr = la;
      chk("mem_addr", 32'(mem_addr), 32'(last_addr));
      if (e_ls && we) chk("mem_data_in", mem_data_in, wd);
      if (push && (e_if || (e_ls && !we))) begin
         e.port = e_ls;
         e.data = e_rd;
         sb.push_back(e);
      end
   endtask

   task automatic idle();
      vec(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; ls_lock = 1'b0;
      last_addr = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: every valid read pops the scoreboard; idle rdata must read as zero.
   always @(negedge clk) begin
      exp_rd_t e;
      chk("rvalid_onehot", 32'(if_rvalid & ls_rvalid), 32'd0);
      if (if_rvalid) begin
         if (sb.size() == 0) begin
            chk("if_rvalid_unexpected", 32'(if_rvalid), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("if_rvalid_port", 32'd0, 32'(e.port));
            chk("if_rdata", if_rdata, e.data);
         end
      end else begin
         chk("if_rdata_idle", if_rdata, 32'd0);
      end
      if (ls_rvalid) begin
         if (sb.size() == 0) begin
            chk("ls_rvalid_unexpected", 32'(ls_rvalid), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("ls_rvalid_port", 32'd1, 32'(e.port));
            chk("ls_rdata", ls_rdata, e.data);
         end
      end else begin
         chk("ls_rdata_idle", ls_rdata, 32'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      if_req = 1'b1; if_addr = 11'd9; ls_req = 1'b1; ls_we = 1'b1; ls_lock = 1'b0;
      ls_addr = 11'd9; ls_wdata = 32'h1234_5678;
      last_addr = '0;
      #3;
      // Reset forces every output quiet even with requests present.
      chk("rst_if_gnt", 32'(if_gnt), 32'd0);
      chk("rst_ls_gnt", 32'(ls_gnt), 32'd0);
      chk("rst_mem_w_en", 32'(mem_w_en), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_data_in", mem_data_in, 32'd0);
      chk("rst_rvalid", 32'({if_rvalid, ls_rvalid}), 32'd0);
      do_reset();

      // Fetch alone, back-to-back addresses 0,1,2.
      vec(1, 11'd0, 0, 0, 0, 11'd0, 32'd0, 1, 0, 32'hA500_0000, 1);
      vec(1, 11'd1, 0, 0, 0, 11'd0, 32'd0, 1, 0, 32'hA500_0001, 1);
      vec(1, 11'd2, 0, 0, 0, 11'd0, 32'd0, 1, 0, 32'hA500_0002, 1);
      idle();
      idle();

      // Both request continuously after reset: IF, LS, IF, LS.
      do_reset();
      vec(1, 11'd10, 1, 0, 0, 11'd20, 32'd0, 1, 0, 32'hA500_000A, 1);
      vec(1, 11'd11, 1, 0, 0, 11'd20, 32'd0, 0, 1, 32'hA500_0014, 1);
      vec(1, 11'd11, 1, 0, 0, 11'd21, 32'd0, 1, 0, 32'hA500_000B, 1);
      vec(1, 11'd12, 1, 0, 0, 11'd21, 32'd0, 0, 1, 32'hA500_0015, 1);
      idle();
      idle();

      // Store then load the same word.
      vec(0, 11'd0, 1, 1, 0, 11'd5, 32'hDEAD_BEEF, 0, 1, 32'd0, 1);
      vec(0, 11'd0, 1, 0, 0, 11'd5, 32'd0, 0, 1, 32'hDEAD_BEEF, 1);
      idle();
      idle();

      // Lock: fetch first so load/store holds the round-robin turn, then 8 locked grants, then fetch.
      vec(1, 11'd3, 0, 0, 0, 11'd0, 32'd0, 1, 0, 32'hA500_0003, 1);
      for (int k = 0; k < 8; k++)
         vec(1, 11'd40, 1, 0, 1, 11'(30 + k), 32'd0, 0, 1, 32'hA500_0000 | 32'(30 + k), 1);
      vec(1, 11'd40, 1, 0, 1, 11'd38, 32'd0, 1, 0, 32'hA500_0028, 1);
      idle();

      // Dropping ls_lock: lock still wins this cycle, then plain round-robin resumes.
      vec(0, 11'd0, 1, 0, 1, 11'd50, 32'd0, 0, 1, 32'hA500_0032, 1);
      vec(1, 11'd41, 1, 0, 0, 11'd51, 32'd0, 0, 1, 32'hA500_0033, 1);
      vec(1, 11'd41, 1, 0, 0, 11'd52, 32'd0, 1, 0, 32'hA500_0029, 1);
      idle();
      idle();

      // Reset while a fetch read is in flight: its data must never appear.
      vec(1, 11'd6, 0, 0, 0, 11'd0, 32'd0, 1, 0, 32'd0, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("inflight_if_gnt", 32'(if_gnt), 32'd0);
      chk("inflight_rvalid", 32'({if_rvalid, ls_rvalid}), 32'd0);
      chk("inflight_mem_addr", 32'(mem_addr), 32'd0);
      chk("inflight_mem_w_en", 32'(mem_w_en), 32'd0);
      last_addr = '0;
      @(negedge clk);
      if_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      vec(1, 11'd7, 1, 0, 0, 11'd8, 32'd0, 1, 0, 32'hA500_0007, 1);
      vec(1, 11'd7, 1, 0, 0, 11'd8, 32'd0, 0, 1, 32'hA500_0008, 1);
      idle();
      idle();
      idle();

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_mem_arbiter
